reg_file_sb: RTL and testbench

// Parametrised multi-read-port register file with scoreboard, next generation of the core's

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_rd_port.sv | 61 ++++++
 rtl/reg_file_sb.sv | 70 +++++++
 tb/tb_reg_file_sb.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared register-file types, default geometry and the zero-index helper.
// Also used by decode hazard logic, so keep is_zero_idx width-agnostic.
package reg_file_pkg;
  localparam int RF_WW = 32;
  localparam int RF_AW = 5;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_WW-1:0] rf_word_t;

  // Callers zero-extend their index to 32 bits so any ADDRESS_WIDTH fits.
  function automatic logic is_zero_idx(input logic [31:0] addr);
    return addr == 32'd0;
  endfunction
endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: RD/BUSY reflect the state after this edge's write/mark.
// Latency 1 cycle; no backpressure, a new address is accepted every cycle.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WORD_WIDTH    = RF_WW,
  parameter int ADDRESS_WIDTH = RF_AW,
  parameter int ZERO_REG      = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [(1 << ADDRESS_WIDTH)*WORD_WIDTH-1:0]    regs,
  input  logic [(1 << ADDRESS_WIDTH)-1:0]               pending,
  input  logic                                          wen,
  input  logic [ADDRESS_WIDTH-1:0]                      wa,
  input  logic [WORD_WIDTH-1:0]                         wd,
  input  logic                                          men,
  input  logic [ADDRESS_WIDTH-1:0]                      ma,
  input  logic [ADDRESS_WIDTH-1:0]                      ra,
  output logic [WORD_WIDTH-1:0]                         rd,
  output logic                                          busy
);

  logic                  zero_hit;
  logic                  wr_hit;
  logic                  mk_hit;
  logic [WORD_WIDTH-1:0] rd_nxt;
  logic                  busy_nxt;

  assign zero_hit = (ZERO_REG != 0) && is_zero_idx(32'(ra));
  assign wr_hit   = wen && (wa == ra);
  assign mk_hit   = men && (ma == ra);

  // Mark is applied after write so a same-cycle re-issue keeps the register pending.
  always_comb begin
    rd_nxt   = regs[ra*WORD_WIDTH +: WORD_WIDTH];
    busy_nxt = pending[ra];
    if (wr_hit) begin
      rd_nxt   = wd;
      busy_nxt = 1'b0;
    end
    if (mk_hit) begin
      busy_nxt = 1'b1;
    end
    if (zero_hit) begin
      rd_nxt   = '0;
      busy_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd   <= '0;
      busy <= 1'b0;
    end else begin
      rd   <= rd_nxt;
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register pending (scoreboard) bits and write bypass.
// Read latency 1 cycle; no backpressure, one write and one mark accepted every cycle.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WORD_WIDTH    = RF_WW,
  parameter int ADDRESS_WIDTH = RF_AW,
  parameter int NUM_RD        = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0]  RA,
  output logic [NUM_RD*WORD_WIDTH-1:0]     RD,
  output logic [NUM_RD-1:0]                BUSY,
  input  logic [ADDRESS_WIDTH-1:0]         WA,
  input  logic [WORD_WIDTH-1:0]            WD,
  input  logic                             WEN,
  input  logic [ADDRESS_WIDTH-1:0]         MA,
  input  logic                             MEN
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DEPTH*WORD_WIDTH-1:0] regs;
  logic [DEPTH-1:0]            pending;
  logic                        wr_ok;
  logic                        mk_ok;

  assign wr_ok = WEN && !((ZERO_REG != 0) && is_zero_idx(32'(WA)));
  assign mk_ok = MEN && !((ZERO_REG != 0) && is_zero_idx(32'(MA)));

  // Mark is the later assignment so it wins over a same-index retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs    <= '0;
      pending <= '0;
    end else begin
      if (wr_ok) begin
        regs[WA*WORD_WIDTH +: WORD_WIDTH] <= WD;
        pending[WA]                       <= 1'b0;
      end
      if (mk_ok) begin
        pending[MA] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    reg_file_rd_port #(
      .WORD_WIDTH    (WORD_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .ZERO_REG      (ZERO_REG)
    ) u_rd_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .regs    (regs),
      .pending (pending),
      .wen     (WEN),
      .wa      (WA),
      .wd      (WD),
      .men     (MEN),
      .ma      (MA),
      .ra      (RA[g*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
      .rd      (RD[g*WORD_WIDTH +: WORD_WIDTH]),
      .busy    (BUSY[g])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vectors plus a random regression for reg_file_sb, run on a ZERO_REG=1 and a
// ZERO_REG=0 instance sharing the same stimulus.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int NRD = 3;

  logic           clk;
  logic           rst_n;
  logic [14:0]    ra;
  logic [4:0]     wa;
  logic [31:0]    wd;
  logic           wen;
  logic [4:0]     ma;
  logic           men;
  logic [95:0]    rd_z;
  logic [2:0]     busy_z;
  logic [95:0]    rd_n;
  logic [2:0]     busy_n;

  int vec_cnt = 0;
  int err_cnt = 0;

  // index 0: ZERO_REG=1 instance, index 1: ZERO_REG=0 instance
  rf_word_t m_mem [2][32];
  logic     m_pend[2][32];

  reg_file_sb #(.WORD_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_RD(NRD), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .RA(ra), .RD(rd_z), .BUSY(busy_z),
    .WA(wa), .WD(wd), .WEN(wen), .MA(ma), .MEN(men)
  );

  reg_file_sb #(.WORD_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_RD(NRD), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .RA(ra), .RD(rd_n), .BUSY(busy_n),
    .WA(wa), .WD(wd), .WEN(wen), .MA(ma), .MEN(men)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded, required finish before 400000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int z = 0; z < 2; z++)
      for (int r = 0; r < 32; r++) begin
        m_mem[z][r]  = '0;
        m_pend[z][r] = 1'b0;
      end
  endtask

  task automatic model_step();
    for (int z = 0; z < 2; z++) begin
      if (wen && !(z == 0 && wa == 5'd0)) begin
        m_mem[z][wa]  = wd;
        m_pend[z][wa] = 1'b0;
      end
      if (men && !(z == 0 && ma == 5'd0)) m_pend[z][ma] = 1'b1;
    end
  endtask

  // Advance one clock: model follows the inputs present at the edge, outputs sampled 1ns later.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model();
    logic [4:0] a;
    for (int p = 0; p < NRD; p++) begin
      a = ra[p*5 +: 5];
      chk($sformatf("rnd_rd_z%0d", p), rd_z[p*32 +: 32], (a == 5'd0) ? 32'd0 : m_mem[0][a]);
      chk($sformatf("rnd_busy_z%0d", p), 32'(busy_z[p]), 32'(m_pend[0][a]));
      chk($sformatf("rnd_rd_n%0d", p), rd_n[p*32 +: 32], m_mem[1][a]);
      chk($sformatf("rnd_busy_n%0d", p), 32'(busy_n[p]), 32'(m_pend[1][a]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ra = '0; wa = '0; wd = '0; wen = 1'b0; ma = '0; men = 1'b0;
    model_clear();
    #12;
    chk("reset_rd_z", rd_z[31:0] | rd_z[63:32] | rd_z[95:64], 32'd0);
    chk("reset_busy_z", 32'(busy_z), 32'd0);
    chk("reset_rd_n", rd_n[31:0] | rd_n[63:32] | rd_n[95:64], 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // write then read
    wen = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF; ra = {5'd1, 5'd1, 5'd1};
    cyc();
    wen = 1'b0; ra = {5'd1, 5'd1, 5'd3};
    cyc();
    chk("wr_rd0", rd_z[31:0], 32'hDEADBEEF);

    // bypass over an older value
    wen = 1'b1; wa = 5'd7; wd = 32'h11111111; ra = {5'd1, 5'd1, 5'd1};
    cyc();
    wa = 5'd7; wd = 32'h12345678; ra = {5'd1, 5'd7, 5'd1};
    cyc();
    chk("bypass_rd1", rd_z[63:32], 32'h12345678);

    // x0 write and mark
    wa = 5'd0; wd = 32'hFFFFFFFF; men = 1'b1; ma = 5'd0; ra = {5'd0, 5'd1, 5'd1};
    cyc();
    chk("x0_rd_z", rd_z[95:64], 32'd0);
    chk("x0_busy_z", 32'(busy_z[2]), 32'd0);
    chk("x0_rd_n", rd_n[95:64], 32'hFFFFFFFF);
    chk("x0_busy_n", 32'(busy_n[2]), 32'd1);

    // scoreboard
    wen = 1'b0; men = 1'b1; ma = 5'd9; ra = {5'd0, 5'd1, 5'd9};
    cyc();
    chk("mark_busy", 32'(busy_z[0]), 32'd1);
    wen = 1'b1; wa = 5'd9; wd = 32'h00000099;
    cyc();
    chk("mark_wins_busy", 32'(busy_z[0]), 32'd1);
    chk("mark_wins_rd", rd_z[31:0], 32'h00000099);
    men = 1'b0; wd = 32'h0000009A;
    cyc();
    chk("retire_busy", 32'(busy_z[0]), 32'd0);
    wen = 1'b0;
    cyc();
    chk("retire_hold", 32'(busy_z[0]), 32'd0);

    // multi-port, identical addresses
    wen = 1'b1; wa = 5'd4; wd = 32'hA5A5A5A5;
    cyc();
    wen = 1'b0; ra = {5'd0, 5'd4, 5'd4};
    cyc();
    chk("mp_rd0", rd_z[31:0], 32'hA5A5A5A5);
    chk("mp_rd1", rd_z[63:32], 32'hA5A5A5A5);
    chk("mp_rd2", rd_z[95:64], 32'd0);
    chk("mp_rd2_n", rd_n[95:64], 32'hFFFFFFFF);

    // hold without writes
    repeat (4) cyc();
    ra = {5'd7, 5'd9, 5'd3};
    cyc();
    chk("hold_r3", rd_z[31:0], 32'hDEADBEEF);
    chk("hold_r9", rd_z[63:32], 32'h0000009A);
    chk("hold_r7", rd_z[95:64], 32'h12345678);

    // reset mid-operation
    wen = 1'b1; wa = 5'd5; wd = 32'h00000055; men = 1'b1; ma = 5'd6; ra = {5'd0, 5'd6, 5'd5};
    cyc();
    chk("pre_rst_rd0", rd_z[31:0], 32'h00000055);
    chk("pre_rst_busy1", 32'(busy_z[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_async_rd_z", rd_z[31:0] | rd_z[63:32] | rd_z[95:64], 32'd0);
    chk("rst_async_busy_z", 32'(busy_z), 32'd0);
    chk("rst_async_rd_n", rd_n[31:0] | rd_n[63:32] | rd_n[95:64], 32'd0);
    repeat (2) @(posedge clk);
    #2;
    wa = 5'd8; wd = 32'h00000088; men = 1'b0; ra = {5'd6, 5'd8, 5'd5};
    rst_n = 1'b1;
    cyc();
    chk("post_rst_x5", rd_z[31:0], 32'd0);
    chk("post_rst_x5_n", rd_n[31:0], 32'd0);
    chk("post_rst_wr8", rd_z[63:32], 32'h00000088);
    chk("post_rst_busy6", 32'(busy_z[2]), 32'd0);

    // random regression against the model, small address range for collisions
    for (int n = 0; n < 300; n++) begin
      wen = 1'($urandom_range(0, 1));
      men = 1'($urandom_range(0, 3) == 0);
      wa  = 5'($urandom_range(0, 7));
      ma  = 5'($urandom_range(0, 7));
      wd  = $urandom;
      ra  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      cyc();
      chk_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
